xor5_parity_sched: RTL and testbench

//  Time-shares one 5-input XOR parity evaluator (sub-module parity5_eval) between NREQ requesters.
//  - Round-robin arbitration over a valid/ready request port per requester.
//  - Registered evaluation; the result is held until the consumer accepts it.
//  - Checks each result against a requester-supplied expected bit and counts mismatches.
//  - Sits between bus-side parity clients and the shared parity datapath.

---
 rtl/xor5_pkg.sv | 43 ++++
 rtl/parity5_eval.sv | 17 +
 rtl/xor5_parity_sched.sv | 161 ++++++++++++++++
 tb/tb_xor5_parity_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor5_pkg.sv
// Shared types and helpers for the XOR5 parity scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
//   state_e  : scheduler FSM states
//   PAR_W    : operand width of the shared parity evaluator
//   rr_pick  : round-robin one-hot pick over up to MAX_REQ requesters
package xor5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int PAR_W   = 5;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Returns onehot of the first set bit of valid, scanning upward from ptr
  // and wrapping at nreq. Returns all zeros when no bit below nreq is set.
  // ptr must be < nreq, so a single subtraction is enough for the wrap.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input logic [3:0]         nreq
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [3:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (4'(k) < nreq) && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/parity5_eval.sv
// Shared 5-input XOR parity evaluator: p = ^d ^ odd.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the result.
//   d   in  PAR_W  operand
//   odd in  1      1 = odd parity, 0 = even parity
//   p   out 1      parity bit
module parity5_eval
  import xor5_pkg::*;
(
  input  logic [PAR_W-1:0] d,
  input  logic             odd,
  output logic             p
);

  assign p = (^d) ^ odd;

endmodule

// File: rtl/xor5_parity_sched.sv
// Round-robin scheduler time-sharing one parity5_eval between NREQ requesters,
// with expected-bit checking and a saturating mismatch counter.
// Latency: transfer in cycle T, res_valid visible in T+2; one result per 3 cycles max.
// Backpressure: result held in HOLD until res_ready; req_ready is 0 outside IDLE.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot, comb)
//   req_data, req_exp        5-bit operand and expected parity per requester
//   mode_odd                 parity mode, sampled at accept
//   res_valid/res_ready      result handshake; res_id, res_parity, res_err payload
//   err_clr, err_count       clear and saturating count of erroneous results
module xor5_parity_sched
  import xor5_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*PAR_W-1:0] req_data,
  input  logic [NREQ-1:0]       req_exp,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  mode_odd,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic                  res_parity,
  output logic                  res_err,
  input  logic                  res_ready,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q,      state_d;
  logic [IDW-1:0]     rr_ptr_q,     rr_ptr_d;
  logic [PAR_W-1:0]   data_q,       data_d;
  logic               exp_q,        exp_d;
  logic               odd_q,        odd_d;
  logic [IDW-1:0]     id_q,         id_d;
  logic               res_valid_q,  res_valid_d;
  logic               res_parity_q, res_parity_d;
  logic               res_err_q,    res_err_d;
  logic [CNT_W-1:0]   err_count_q,  err_count_d;

  logic [MAX_REQ-1:0] valid_ext;
  logic [PTR_W-1:0]   ptr_ext;
  logic [MAX_REQ-1:0] pick_full;
  logic [NREQ-1:0]    grant;
  logic               eval_p;
  logic               unused_pick;

  // Widen to the package helper's fixed width; upper bits stay zero.
  always_comb begin
    valid_ext               = '0;
    valid_ext[NREQ-1:0]     = req_valid;
    ptr_ext                 = '0;
    ptr_ext[IDW-1:0]        = rr_ptr_q;
  end

  assign pick_full   = rr_pick(valid_ext, ptr_ext, 4'(NREQ));
  assign grant       = pick_full[NREQ-1:0];
  assign unused_pick = ^pick_full;

  parity5_eval u_eval (
    .d   (data_q),
    .odd (odd_q),
    .p   (eval_p)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    data_d       = data_q;
    exp_d        = exp_q;
    odd_d        = odd_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    res_err_d    = res_err_q;
    err_count_d  = err_count_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        // grant is non-zero only when some requester is valid, so a non-zero
        // grant is itself the transfer.
        req_ready = grant;
        if (|grant) begin
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              data_d = req_data[PAR_W*i +: PAR_W];
              exp_d  = req_exp[i];
              id_d   = IDW'(i);
            end
          end
          odd_d   = mode_odd;
          state_d = EVAL;
        end
      end
      EVAL: begin
        res_parity_d = eval_p;
        res_err_d    = eval_p ^ exp_q;
        res_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
          // Pointer moves past the requester just served, only on completion.
          if (id_q == IDW'(NREQ-1)) rr_ptr_d = '0;
          else                      rr_ptr_d = id_q + IDW'(1);
          if (res_err_q && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over a coincident increment.
    if (err_clr) err_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      exp_q        <= 1'b0;
      odd_q        <= 1'b0;
      id_q         <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      data_q       <= data_d;
      exp_q        <= exp_d;
      odd_q        <= odd_d;
      id_q         <= id_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
      res_err_q    <= res_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_id     = id_q;
  assign res_parity = res_parity_q;
  assign res_err    = res_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_xor5_parity_sched.sv
// Self-checking bench for xor5_parity_sched against a transaction-level model.
// Latency: n/a.
// Backpressure: exercised through res_ready hold periods.
module tb_xor5_parity_sched;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*5-1:0]   req_data;
  logic [NREQ-1:0]     req_exp;
  logic [NREQ-1:0]     req_ready;
  logic                mode_odd;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic                res_parity;
  logic                res_err;
  logic                res_ready;
  logic                err_clr;
  logic [CNT_W-1:0]    err_count;

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  xor5_parity_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_exp    (req_exp),
    .req_ready  (req_ready),
    .mode_odd   (mode_odd),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_parity (res_parity),
    .res_err    (res_err),
    .res_ready  (res_ready),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin winner from the model pointer, -1 when nothing is valid.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic scramble();
    req_valid = 4'($urandom);
    req_data  = 20'($urandom);
    req_exp   = 4'($urandom);
    mode_odd  = 1'($urandom);
  endtask

  // One transaction starting in an IDLE cycle (called just after a posedge).
  task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ*5-1:0] dat,
                        input logic [NREQ-1:0] ex, input logic odd,
                        input int hold, input logic clr, output int w);
    logic [4:0] opnd;
    int         ones;
    logic       ep;
    logic       ee;
    req_valid = v;
    req_data  = dat;
    req_exp   = ex;
    mode_odd  = odd;
    res_ready = 1'($urandom);
    err_clr   = 1'b0;
    #1;
    w = model_pick(v);
    if (w < 0) begin
      check("idle_rdy", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      return;
    end
    check("grant", 32'(req_ready), 32'(1) << w);
    check("idle_rv", 32'(res_valid), 32'(0));
    opnd = dat[5*w +: 5];
    ones = $countones(opnd);
    ep   = (((ones + (odd ? 1 : 0)) % 2) == 1);
    ee   = (ep != ex[w]);

    @(posedge clk);
    #1;
    scramble();
    res_ready = 1'($urandom);
    #1;
    check("eval_rdy", 32'(req_ready), 32'(0));
    check("eval_rv", 32'(res_valid), 32'(0));

    @(posedge clk);
    #1;
    for (int h = 0; h <= hold; h++) begin
      scramble();
      res_ready = (h == hold);
      err_clr   = (h == hold) ? clr : 1'b0;
      #1;
      check("hold_rv", 32'(res_valid), 32'(1));
      check("hold_id", 32'(res_id), 32'(w));
      check("hold_par", 32'(res_parity), 32'(ep));
      check("hold_err", 32'(res_err), 32'(ee));
      check("hold_rdy", 32'(req_ready), 32'(0));
      check("hold_cnt", 32'(err_count), 32'(m_cnt));
      @(posedge clk);
      #1;
    end
    if (clr) m_cnt = 0;
    else if (ee && m_cnt < 255) m_cnt++;
    m_ptr     = (w + 1) % NREQ;
    res_ready = 1'b0;
    err_clr   = 1'b0;
    req_valid = '0;
    #1;
    check("done_rv", 32'(res_valid), 32'(0));
    check("done_cnt", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_exp   = '0;
    mode_odd  = 1'b0;
    res_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    #1;
    check("rst_rv", 32'(res_valid), 32'(0));
    check("rst_id", 32'(res_id), 32'(0));
    check("rst_par", 32'(res_parity), 32'(0));
    check("rst_err", 32'(res_err), 32'(0));
    check("rst_cnt", 32'(err_count), 32'(0));
    check("rst_rdy", 32'(req_ready), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    do_reset();

    // Single request on requester 0: 10110, expect 1, even mode.
    do_txn(4'b0001, 20'b10110, 4'b0001, 1'b0, 0, 1'b0, w);
    check("t2_id", 32'(w), 32'(0));

    // All requesters valid from a fresh pointer: strict rotation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(4'hF, 20'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0, w);
      check("rot_id", 32'(w), 32'(i % NREQ));
    end

    // Long backpressure, then the next grant goes to id+1.
    do_txn(4'hF, 20'($urandom), 4'($urandom), 1'($urandom), 10, 1'b0, w);
    do_txn(4'hF, 20'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0, w);

    // Mismatch path and counter saturation.
    do_reset();
    do_txn(4'b0001, 20'b11111, 4'b0000, 1'b1, 0, 1'b0, w);
    check("mm_cnt0", 32'(err_count), 32'(0));
    do_txn(4'b0001, 20'b11111, 4'b0001, 1'b1, 0, 1'b0, w);
    check("mm_cnt1", 32'(err_count), 32'(1));
    for (int i = 0; i < 300; i++) begin
      do_txn(4'b0001, 20'b11111, 4'b0001, 1'b1, 0, 1'b0, w);
    end
    check("sat_cnt", 32'(err_count), 32'(255));
    do_txn(4'b0001, 20'b11111, 4'b0001, 1'b1, 0, 1'b1, w);
    check("clr_cnt", 32'(err_count), 32'(0));

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom_range(0, 15)), 20'($urandom), 4'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), w);
    end

    // Reset while holding a result: pointer must return to 0.
    do_txn(4'b0010, 20'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0, w);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    #1;
    check("pre_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    check("pre_rst_rv", 32'(res_valid), 32'(1));
    rst       = 1'b1;
    req_valid = 4'b1010;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    #1;
    check("hr_rv", 32'(res_valid), 32'(0));
    check("hr_id", 32'(res_id), 32'(0));
    check("hr_cnt", 32'(err_count), 32'(0));
    check("hr_rdy", 32'(req_ready), 32'(4'b0010));
    do_txn(4'b1010, 20'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0, w);
    do_txn(4'b1000, 20'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0, w);
    check("hr_id3", 32'(w), 32'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
